// File: rtl/insmem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings, halt marker, word size.
package insmem_loader_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCollect = 3'd1;
  localparam logic [2:0] StWrite   = 3'd2;
  localparam logic [2:0] StDone    = 3'd3;
  localparam logic [2:0] StError   = 3'd4;

  localparam logic [31:0] HaltWordDefault = 32'hFFFF_FFFF;
  localparam int unsigned WordBytes       = 4;

endpackage

// File: rtl/insmem_loader_packer.sv
// Assembles big-endian program bytes into 32-bit words and counts bytes within the word.
module byte_packer
  import insmem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  // High on the cycle the last byte of a word is being accepted.
  assign full_o = shift_i && (cnt_q == 2'(WordBytes - 1));

endmodule

// File: rtl/insmem_loader.sv
// Streams program bytes into INSMEM as 32-bit words until the halt word or memory is full.
module insmem_loader
  import insmem_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_WORDS = 256,
  parameter logic [31:0] HALT_WORD       = HaltWordDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        write_en,
  output logic [31:0] addr_wr,
  output logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count
);

  localparam logic [15:0] LastSlot = 16'(MEM_DEPTH_WORDS - 1);
  localparam logic [31:0] AddrStep = 32'(WordBytes);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_wr_q, addr_wr_d;
  logic [15:0] word_count_q, word_count_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic        rx_ready_q, rx_ready_d;
  logic        write_en_q, write_en_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        clear_cnt;
  logic        word_full;
  logic [31:0] packed_word;

  assign accept = rx_valid & rx_ready_q;

  byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_cnt),
    .shift_i (accept),
    .byte_i  (rx_data),
    .word_o  (packed_word),
    .full_o  (word_full)
  );

  always_comb begin
    state_d      = state_q;
    addr_wr_d    = addr_wr_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    clear_cnt    = 1'b0;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d      = StCollect;
          addr_wr_d    = '0;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
          clear_cnt    = 1'b1;
        end
      end
      StCollect: begin
        if (word_full) state_d = StWrite;
      end
      StWrite: begin
        addr_wr_d    = addr_wr_q + AddrStep;
        word_count_d = word_count_q + 16'd1;
        // The halt word is itself written; it wins over the full-memory check.
        if (packed_word == HALT_WORD) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (word_count_q == LastSlot) begin
          state_d    = StError;
          overflow_d = 1'b1;
        end else begin
          state_d = StCollect;
        end
      end
      default: state_d = StIdle;
    endcase
    // Handshake/strobe outputs are registered from the next state.
    rx_ready_d = (state_d == StCollect);
    write_en_d = (state_d == StWrite);
    busy_d     = rx_ready_d | write_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_wr_q    <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      rx_ready_q   <= 1'b0;
      write_en_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_wr_q    <= addr_wr_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      rx_ready_q   <= rx_ready_d;
      write_en_q   <= write_en_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign write_en   = write_en_q;
  assign addr_wr    = addr_wr_q;
  assign data       = packed_word;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_insmem_loader.sv
// Scoreboard bench: two loaders (default depth and depth 4) feeding behavioural INSMEM arrays.
module tb_insmem_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        sel = 1'b0;

  logic        start_a, valid_a, rx_ready_a, we_a, busy_a, done_a, ovf_a;
  logic [31:0] addr_a, data_a;
  logic [15:0] wc_a;
  logic        start_b, valid_b, rx_ready_b, we_b, busy_b, done_b, ovf_b;
  logic [31:0] addr_b, data_b;
  logic [15:0] wc_b;

  logic        cur_ready, cur_busy;
  logic        prev_we_a = 1'b0, prev_we_b = 1'b0;

  logic [31:0] insmem_a [256];
  logic [31:0] insmem_b [4];
  wr_t         exp_a [$];
  wr_t         exp_b [$];
  logic [7:0]  prog [12];

  int          n_checks = 0;
  int          n_errors = 0;

  assign start_a   = start & ~sel;
  assign valid_a   = rx_valid & ~sel;
  assign start_b   = start & sel;
  assign valid_b   = rx_valid & sel;
  assign cur_ready = sel ? rx_ready_b : rx_ready_a;
  assign cur_busy  = sel ? busy_b : busy_a;

  always #5 clk = ~clk;

  insmem_loader dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .rx_data    (rx_data),
    .rx_valid   (valid_a),
    .rx_ready   (rx_ready_a),
    .write_en   (we_a),
    .addr_wr    (addr_a),
    .data       (data_a),
    .busy       (busy_a),
    .done       (done_a),
    .overflow   (ovf_a),
    .word_count (wc_a)
  );

  insmem_loader #(
    .MEM_DEPTH_WORDS (4)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .rx_data    (rx_data),
    .rx_valid   (valid_b),
    .rx_ready   (rx_ready_b),
    .write_en   (we_b),
    .addr_wr    (addr_b),
    .data       (data_b),
    .busy       (busy_b),
    .done       (done_b),
    .overflow   (ovf_b),
    .word_count (wc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // INSMEM models plus scoreboard comparison of every write strobe.
  always @(negedge clk) begin
    if (!reset && we_a) begin
      check("a_we_single_cycle", {31'd0, prev_we_a}, 32'd0);
      check("a_ready_in_write", {31'd0, rx_ready_a}, 32'd0);
      check("a_addr_aligned", {30'd0, addr_a[1:0]}, 32'd0);
      if (exp_a.size() == 0) begin
        check("a_unexpected_write", addr_a, 32'hDEAD_BEEF);
      end else begin
        wr_t e;
        e = exp_a.pop_front();
        check("a_wr_addr", addr_a, e.addr);
        check("a_wr_data", data_a, e.data);
        insmem_a[addr_a[9:2]] = data_a;
      end
    end
    prev_we_a <= we_a;
  end

  always @(negedge clk) begin
    if (!reset && we_b) begin
      check("b_we_single_cycle", {31'd0, prev_we_b}, 32'd0);
      if (exp_b.size() == 0) begin
        check("b_unexpected_write", addr_b, 32'hDEAD_BEEF);
      end else begin
        wr_t e;
        e = exp_b.pop_front();
        check("b_wr_addr", addr_b, e.addr);
        check("b_wr_data", data_b, e.data);
        insmem_b[addr_b[3:2]] = data_b;
      end
    end
    prev_we_b <= we_b;
  end

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] dat);
    wr_t e;
    e.addr = addr;
    e.data = dat;
    if (sel) exp_b.push_back(e);
    else exp_a.push_back(e);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cur_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, cur_busy}, 32'd0);
  endtask

  task automatic run_program(input bit gaps, input bit poke_start);
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) push_exp(32'(i), {prog[i], prog[i+1], prog[i+2], prog[i+3]});
      if (poke_start && i == 5) start = 1'b1;
      send_byte(prog[i]);
      start = 1'b0;
      if (gaps) repeat ($urandom_range(3, 0)) @(negedge clk);
    end
  endtask

  task automatic check_a_cleared(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready_a}, 32'd0);
    check({tag, "_write_en"}, {31'd0, we_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_done"}, {31'd0, done_a}, 32'd0);
    check({tag, "_overflow"}, {31'd0, ovf_a}, 32'd0);
    check({tag, "_addr"}, addr_a, 32'd0);
    check({tag, "_data"}, data_a, 32'd0);
    check({tag, "_count"}, {16'd0, wc_a}, 32'd0);
  endtask

  initial begin
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};

    repeat (3) @(negedge clk);
    check_a_cleared("reset");
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back stream with start poked mid-session.
    pulse_start();
    check("s1_busy", {31'd0, busy_a}, 32'd1);
    check("s1_ready", {31'd0, rx_ready_a}, 32'd1);
    run_program(1'b0, 1'b1);
    wait_idle("s1_idle");
    check("s1_done", {31'd0, done_a}, 32'd1);
    check("s1_overflow", {31'd0, ovf_a}, 32'd0);
    check("s1_count", {16'd0, wc_a}, 32'd3);
    check("s1_queue_empty", exp_a.size(), 32'd0);
    check("s1_mem0", insmem_a[0], 32'h2008_0005);
    check("s1_mem1", insmem_a[1], 32'h2009_000A);
    check("s1_mem2", insmem_a[2], 32'hFFFF_FFFF);

    // Restart from DONE, with random idle gaps between bytes.
    pulse_start();
    check("s2_count_cleared", {16'd0, wc_a}, 32'd0);
    check("s2_addr_cleared", addr_a, 32'd0);
    check("s2_done_cleared", {31'd0, done_a}, 32'd0);
    run_program(1'b1, 1'b0);
    wait_idle("s2_idle");
    check("s2_done", {31'd0, done_a}, 32'd1);
    check("s2_count", {16'd0, wc_a}, 32'd3);
    check("s2_queue_empty", exp_a.size(), 32'd0);

    // Reset discards a partial word.
    pulse_start();
    send_byte(8'h20);
    send_byte(8'h08);
    reset = 1'b1;
    @(negedge clk);
    check_a_cleared("midreset");
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    push_exp(32'd0, 32'h200A_000F);
    send_byte(8'h20);
    send_byte(8'h0A);
    send_byte(8'h00);
    send_byte(8'h0F);
    repeat (3) @(negedge clk);
    check("s3_queue_empty", exp_a.size(), 32'd0);
    check("s3_count", {16'd0, wc_a}, 32'd1);
    check("s3_addr", addr_a, 32'd4);
    check("s3_done", {31'd0, done_a}, 32'd0);

    // Depth-4 loader overflows without a halt word.
    sel = 1'b1;
    pulse_start();
    for (int w = 1; w <= 4; w++) begin
      push_exp(32'((w - 1) * 4), 32'(w));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'(w));
    end
    wait_idle("s4_idle");
    check("s4_overflow", {31'd0, ovf_b}, 32'd1);
    check("s4_done", {31'd0, done_b}, 32'd0);
    check("s4_count", {16'd0, wc_b}, 32'd4);
    check("s4_queue_empty", exp_b.size(), 32'd0);
    check("s4_mem3", insmem_b[3], 32'd4);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("s4_ready_after_ovf", {31'd0, rx_ready_b}, 32'd0);
    end
    rx_valid = 1'b0;
    check("s4_no_extra_write", exp_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
